mole_hit_judge: RTL

Scoring and judging block for the whack-a-mole game: the consumer end of the mole-position interface. It watches the 3-bit mole position from the mole state generator alongside the eight player hole keys. Each mole round is judged as a hit or a miss, with a saturating two-digit BCD score and a miss count kept. The game ends when the miss limit is reached. Outputs drive the seven-segment score display and the mole/hole display logic.

---
 rtl/whack_pkg.sv | 22 ++
 rtl/bcd_score_counter.sv | 23 ++
 rtl/mole_hit_judge.sv | 115 +++++++++++
 3 files changed

// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole blocks: hole count, mole index width,
// judge FSM states and the one-hot hole helper.
package whack_pkg;

    localparam int NUM_HOLES = 8;
    localparam int MOLE_W    = 3;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2,
        OVER  = 2'd3
    } judge_state_t;

    function automatic logic [NUM_HOLES-1:0] onehot8(input logic [MOLE_W-1:0] idx);
        logic [NUM_HOLES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score, +1 per inc pulse, saturating at 99; one-cycle update latency.
// No backpressure: inc is always accepted, ignored once the score is at 99.
module bcd_score_counter (
    input  logic       clk,
    input  logic       key_esc,
    input  logic       inc,
    output logic [7:0] score
);

    always_ff @(posedge clk) begin
        if (!key_esc) begin
            score <= 8'h00;
        end else if (inc && (score != 8'h99)) begin
            if (score[3:0] == 4'd9) begin
                score[3:0] <= 4'd0;
                score[7:4] <= score[7:4] + 4'd1;
            end else begin
                score[3:0] <= score[3:0] + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mole_hit_judge.sv
// Judges each mole round as hit or miss, keeps BCD score and miss count, ends the game at MAX_MISSES.
// All outputs registered: a key edge or mole change in cycle N is reflected in cycle N+1; no backpressure.
module mole_hit_judge
    import whack_pkg::*;
#(
    parameter int MAX_MISSES = 5
) (
    input  logic                 clk,
    input  logic                 key_esc,
    input  logic [MOLE_W-1:0]    mole_current_state,
    input  logic [NUM_HOLES-1:0] key_hit,
    output logic [7:0]           score_bcd,
    output logic [2:0]           miss_count,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 mole_active,
    output logic                 game_over
);

    localparam logic [2:0] MISS_LIMIT = 3'(MAX_MISSES);

    judge_state_t         state;
    logic [MOLE_W-1:0]    target_q;
    logic [NUM_HOLES-1:0] key_prev;

    logic [NUM_HOLES-1:0] key_edge;
    logic                 moved;
    logic                 hit_now;
    logic                 miss_now;
    logic [2:0]           miss_next;

    always_comb begin
        key_edge  = key_hit & ~key_prev;
        moved     = (mole_current_state != target_q);
        hit_now   = 1'b0;
        miss_now  = 1'b0;
        miss_next = miss_count + 3'd1;
        if (state == ARMED) begin
            // A key edge always judges against the old target, even if the mole moves in the same cycle.
            hit_now  = (key_edge == onehot8(target_q));
            miss_now = !hit_now && ((key_edge != '0) || moved);
        end
    end

    always_ff @(posedge clk) begin
        if (!key_esc) begin
            state       <= WAIT;
            target_q    <= '0;
            key_prev    <= '1;
            miss_count  <= 3'd0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            mole_active <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            key_prev   <= key_hit;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                WAIT: begin
                    target_q    <= mole_current_state;
                    state       <= ARMED;
                    mole_active <= 1'b1;
                end
                ARMED: begin
                    if (hit_now) begin
                        hit_pulse <= 1'b1;
                        if (moved) begin
                            target_q <= mole_current_state;
                        end else begin
                            state       <= DONE;
                            mole_active <= 1'b0;
                        end
                    end else if (miss_now) begin
                        miss_pulse <= 1'b1;
                        miss_count <= miss_next;
                        if (miss_next == MISS_LIMIT) begin
                            state       <= OVER;
                            game_over   <= 1'b1;
                            mole_active <= 1'b0;
                        end else if (moved) begin
                            target_q <= mole_current_state;
                        end else begin
                            state       <= DONE;
                            mole_active <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (moved) begin
                        target_q    <= mole_current_state;
                        state       <= ARMED;
                        mole_active <= 1'b1;
                    end
                end
                OVER: begin
                    mole_active <= 1'b0;
                    game_over   <= 1'b1;
                end
                default: begin
                    state       <= WAIT;
                    mole_active <= 1'b0;
                end
            endcase
        end
    end

    bcd_score_counter u_score (
        .clk     (clk),
        .key_esc (key_esc),
        .inc     (hit_now),
        .score   (score_bcd)
    );

endmodule
